// File: rtl/adder_issue_pkg.sv
// Shared types and defaults for the adiabatic-adder issue/capture sequencer.
package adder_issue_pkg;

    localparam int DEFAULT_WIDTH          = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        EVAL = 2'd2,
        RESP = 2'd3
    } issue_state_t;

endpackage

// File: rtl/adder_issue_ctrl_rise_detect.sv
// Bennett-boundary detector: registers instFlag and flags its rising edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic flag_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= d;
        end
    end

    assign rise = d & ~flag_q;

endmodule

// File: rtl/adder_issue_ctrl.sv
// Issues operands to the adiabatic adder on Bennett boundaries and captures the result one sweep later.
// Optional build macro ADDER_ISSUE_CHECK_EN adds a sticky mismatch_err self-check of the adder output.
module adder_issue_ctrl
    import adder_issue_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instFlag,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
`ifdef ADDER_ISSUE_CHECK_EN
    output logic             mismatch_err,
`endif
    output logic             timeout_err
);

    localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    issue_state_t     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [WIDTH-1:0] hold_a_reg, hold_b_reg;
    logic             hold_cin_reg;
    logic [WIDTH-1:0] add_a_reg, add_b_reg;
    logic             add_cin_reg;
    logic [WIDTH-1:0] res_sum_reg;
    logic             res_cout_reg;
    logic             res_valid_reg;
    logic             timeout_err_reg;

    logic rise;
    logic at_limit;
    logic accept, load, capture, expire, drain;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .d     (instFlag),
        .rise  (rise)
    );

    assign at_limit = (cnt_reg == CNT_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A late boundary loses to the timeout so a stalled sweep is never half-reported.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = ARM;
            ARM: begin
                if (at_limit)  state_next = IDLE;
                else if (rise) state_next = EVAL;
            end
            EVAL: begin
                if (at_limit)  state_next = IDLE;
                else if (rise) state_next = RESP;
            end
            RESP: if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        accept   = 1'b0;
        load     = 1'b0;
        capture  = 1'b0;
        expire   = 1'b0;
        drain    = 1'b0;
        cnt_next = '0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            ARM: begin
                if (at_limit)  expire   = 1'b1;
                else if (rise) load     = 1'b1;
                else           cnt_next = cnt_reg + 1'b1;
            end
            EVAL: begin
                if (at_limit)  expire   = 1'b1;
                else if (rise) capture  = 1'b1;
                else           cnt_next = cnt_reg + 1'b1;
            end
            RESP: drain = res_ready;
            default: ;
        endcase
    end

    // Adder inputs move only on the ARM boundary so the sweep sees static operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg         <= '0;
            hold_a_reg      <= '0;
            hold_b_reg      <= '0;
            hold_cin_reg    <= 1'b0;
            add_a_reg       <= '0;
            add_b_reg       <= '0;
            add_cin_reg     <= 1'b0;
            res_sum_reg     <= '0;
            res_cout_reg    <= 1'b0;
            res_valid_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (accept) begin
                hold_a_reg   <= in_a;
                hold_b_reg   <= in_b;
                hold_cin_reg <= in_cin;
            end
            if (load) begin
                add_a_reg   <= hold_a_reg;
                add_b_reg   <= hold_b_reg;
                add_cin_reg <= hold_cin_reg;
            end
            if (capture) begin
                res_sum_reg  <= add_sum;
                res_cout_reg <= add_cout;
            end
            if (capture) begin
                res_valid_reg <= 1'b1;
            end else if (drain) begin
                res_valid_reg <= 1'b0;
            end
            if (expire) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

`ifdef ADDER_ISSUE_CHECK_EN
    logic [WIDTH:0] ref_sum;
    logic           mismatch_err_reg;

    assign ref_sum = {1'b0, add_a_reg} + {1'b0, add_b_reg} + {{WIDTH{1'b0}}, add_cin_reg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatch_err_reg <= 1'b0;
        end else if (capture && ({add_cout, add_sum} != ref_sum)) begin
            mismatch_err_reg <= 1'b1;
        end
    end

    assign mismatch_err = mismatch_err_reg;
`endif

    assign add_a       = add_a_reg;
    assign add_b       = add_b_reg;
    assign add_cin     = add_cin_reg;
    assign res_valid   = res_valid_reg;
    assign res_sum     = res_sum_reg;
    assign res_cout    = res_cout_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Scoreboard bench for adder_issue_ctrl with a behavioural adder and a periodic instFlag generator.
module tb_adder_issue_ctrl;

    localparam int WIDTH  = 16;
    localparam int TMO    = 32;
    localparam int PERIOD = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             instFlag = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             timeout_err;
`ifdef ADDER_ISSUE_CHECK_EN
    logic             mismatch_err;
`endif

    always #5 clk = ~clk;

    // Behavioural stand-in for the adiabatic adder netlist.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    adder_issue_ctrl #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .instFlag    (instFlag),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cin      (in_cin),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_cin     (add_cin),
        .add_sum     (add_sum),
        .add_cout    (add_cout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_cout    (res_cout),
`ifdef ADDER_ISSUE_CHECK_EN
        .mismatch_err(mismatch_err),
`endif
        .timeout_err (timeout_err)
    );

    int               errors = 0;
    int               checks = 0;
    logic [WIDTH:0]   sb[$];
    bit               flag_en = 1'b1;
    int               phase = 0;
    bit               next_rise = 1'b0;
    bit               in_flight = 1'b0;
    int               nrise = 0;
    logic [2*WIDTH:0] prev_add = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: handshakes decided before the edge are retired after it, then instFlag advances.
    task automatic tick();
        bit             acc, rsp, was_rise, nf;
        logic [WIDTH:0] rv, e;
        acc      = in_valid && in_ready;
        rsp      = res_valid && res_ready;
        rv       = {res_cout, res_sum};
        was_rise = next_rise;
        @(negedge clk);
        if (acc) begin
            sb.push_back({1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin});
            $display("accept a=%h b=%h cin=%b", in_a, in_b, in_cin);
            in_valid  = 1'b0;
            in_flight = 1'b1;
            nrise     = 0;
        end else if (in_flight && was_rise) begin
            nrise++;
        end
        if (in_flight && res_valid) begin
            in_flight = 1'b0;
            check("lat_rises", nrise, 2);
        end
        if (rsp) begin
            if (sb.size() == 0) begin
                check("unexpected_res", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("result sum=%h cout=%b", rv[WIDTH-1:0], rv[WIDTH]);
                check("res_sum", rv[WIDTH-1:0], e[WIDTH-1:0]);
                check("res_cout", rv[WIDTH], e[WIDTH]);
            end
        end
        if ({add_cin, add_a, add_b} !== prev_add) begin
            check("add_on_rise", was_rise, 1);
            prev_add = {add_cin, add_a, add_b};
        end
        phase     = (phase + 1) % PERIOD;
        nf        = flag_en && (phase == 0);
        next_rise = nf && !instFlag;
        instFlag  = nf;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        for (int i = 0; i < 60 && in_valid; i++) tick();
        if (in_valid) begin
            check("accept_wait", 0, 1);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            check("result_wait", 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        bit rv_seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_add_a", add_a, 0);
        check("rst_res_sum", res_sum, 0);
        check("rst_timeout", timeout_err, 0);
        @(negedge clk);
        reset = 1'b1;

        res_ready = 1'b1;
        send(16'h000F, 16'h0001, 1'b0);
        wait_done();
        send(16'h0011, 16'hFF11, 1'b1);
        wait_done();
        send(16'hFFFF, 16'hFFFF, 1'b0);
        wait_done();

        // Back-pressure: result must sit still while the consumer stalls.
        res_ready = 1'b0;
        send(16'h1234, 16'h5678, 1'b1);
        for (int i = 0; i < 100 && !res_valid; i++) tick();
        check("bp_res_valid", res_valid, 1);
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i % 10 == 0) begin
                check("bp_hold_valid", res_valid, 1);
                check("bp_hold_sum", res_sum, 16'h68AD);
                check("bp_in_ready", in_ready, 0);
            end
        end
        res_ready = 1'b1;
        wait_done();

        // Acceptance on a boundary cycle must wait for the following boundary.
        for (int i = 0; i < 2 * PERIOD && !next_rise; i++) tick();
        send(16'h0A0A, 16'h0505, 1'b0);
        check("same_rise_noload", add_a, 16'h1234);
        wait_done();

        // Timeout with no boundaries at all.
        flag_en = 1'b0;
        rv_seen = 1'b0;
        send(16'hAAAA, 16'h5555, 1'b0);
        for (int i = 0; i < 25; i++) begin tick(); rv_seen |= res_valid; end
        check("tmo_early", timeout_err, 0);
        for (int i = 0; i < 15; i++) begin tick(); rv_seen |= res_valid; end
        check("tmo_set", timeout_err, 1);
        check("tmo_idle", in_ready, 1);
        check("tmo_no_valid", rv_seen, 0);
        sb.delete();
        in_flight = 1'b0;
        flag_en   = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("tmo_sticky", timeout_err, 1);

        // Asynchronous reset while the adder is evaluating.
        send(16'h4321, 16'h1111, 1'b0);
        for (int i = 0; i < 30 && nrise < 1; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        check("arst_add_a", add_a, 0);
        check("arst_add_b", add_b, 0);
        check("arst_add_cin", add_cin, 0);
        check("arst_res_valid", res_valid, 0);
        check("arst_timeout", timeout_err, 0);
        check("arst_in_ready", in_ready, 1);
        sb.delete();
        in_flight = 1'b0;
        prev_add  = {add_cin, add_a, add_b};
        @(negedge clk);
        reset     = 1'b1;
        next_rise = instFlag;
        send(16'h00FF, 16'h0F01, 1'b1);
        wait_done();
`ifdef ADDER_ISSUE_CHECK_EN
        check("mismatch_err", mismatch_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_issue_ctrl.md
Name: adder_issue_ctrl

Overview:
Sequencing stage directly upstream and downstream of the 16-bit adiabatic adder. It accepts operand transactions on a valid/ready interface and drives them onto the adder inputs, changing them only at a Bennett-cycle boundary (instFlag rising edge). It then holds them stable for one full Bennett sweep, captures out/cout at the next boundary, and returns the result on a valid/ready interface. It replaces the hand-timed operand changes and instFlag waits currently done in benches.

Parameters:
WIDTH, 16, operand/result width; must match the adder netlist.
TIMEOUT_CYCLES, 1024, maximum clk cycles allowed in ARM or EVAL without an instFlag rising edge.

Ports:
clk  input  1  system clock; same clock that drives bennett_clock.
reset  input  1  asynchronous, active-low reset: reset=0 resets the block.
instFlag  input  1  Bennett cycle-complete flag from bennett_clock; synchronous to clk.
in_valid  input  1  operand transaction valid.
in_ready  output  1  block can accept an operand transaction.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in.
add_a  output  WIDTH  to adder a[].
add_b  output  WIDTH  to adder b[].
add_cin  output  1  to adder cin.
add_sum  input  WIDTH  from adder out[].
add_cout  input  1  from adder cout.
res_valid  output  1  result valid.
res_ready  input  1  result consumer ready.
res_sum  output  WIDTH  captured sum.
res_cout  output  1  captured carry-out.
timeout_err  output  1  sticky: a Bennett boundary failed to arrive in time.

Behaviour:
- Reset (reset=0, asynchronous) puts the block in state IDLE. Reset values: add_a/add_b/add_cin=0, res_sum/res_cout=0, res_valid=0, timeout_err=0, hold registers=0, flag_q=0, timeout counter=0.
- Boundary detection: rise = instFlag & ~flag_q, where flag_q is instFlag registered on clk.
- States:
  - IDLE: in_ready=1. When in_valid=1, latch in_a/in_b/in_cin into the hold registers and go to ARM. add_* keep their last values.
  - ARM: wait for rise. On rise, load add_* from the hold registers and go to EVAL. A rise in the same cycle as acceptance is not seen, because detection happens only in ARM.
  - EVAL: add_* held constant. On the next rise, capture res_sum=add_sum and res_cout=add_cout, set res_valid=1, and go to RESP.
  - RESP: res_valid=1 and res_sum/res_cout held stable until res_ready=1. On that cycle, clear res_valid and go to IDLE. in_ready=0 throughout RESP; a new transaction is accepted one cycle later at the earliest.
- add_* change only on a rise cycle in ARM. They never change in IDLE, EVAL or RESP, so adiabatic inputs stay static across a sweep.
- Latency: one Bennett cycle minimum (accepted just before a rise) plus one clk cycle for capture; two Bennett cycles maximum.
- Arithmetic: no arithmetic is done in the block. The result is exactly the adder output, WIDTH bits plus cout.
- Timeout:
  - The counter counts clk cycles in ARM and EVAL and clears on every rise and on entry to ARM.
  - When the counter reaches TIMEOUT_CYCLES, set timeout_err (sticky until reset), drop the transaction, do not assert res_valid, and go to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Reset asserted mid-operation: the transaction is discarded immediately and nothing is reported.

Optional Feature:
ADDER_ISSUE_CHECK_EN.
- Defined: adds output mismatch_err (1 bit, sticky, reset 0). On the EVAL capture cycle, compare {add_cout, add_sum} against add_a + add_b + add_cin computed at WIDTH+1 bits; any difference sets mismatch_err.
- Undefined: no port, no comparator logic.

Decomposition:
- Package adder_issue_pkg: state enum (IDLE, ARM, EVAL, RESP), default WIDTH and TIMEOUT_CYCLES localparams.
- One sub-module, rise_detect (clk, reset, d -> rise): the flag_q register plus the edge AND.
- Everything else lives in adder_issue_ctrl.

Test Plan:
- a=000F, b=0001, cin=0, res_ready tied 1 -> res_sum=0010, res_cout=0; add_* change only on a rise cycle.
- a=0011, b=FF11, cin=1 -> res_sum=FF23, res_cout=0. Then a=FFFF, b=FFFF, cin=0 -> res_sum=FFFE, res_cout=1.
- a=1234, b=5678, cin=1 with res_ready=0 for 50 cycles -> res_valid=1 and res_sum=68AD held stable; in_ready=0 until res_ready pulses.
- Accept a transaction in the same cycle as a rise -> add_* load on the following rise, not this one; the result arrives two boundaries later.
- instFlag held 0 after acceptance, TIMEOUT_CYCLES=32 -> timeout_err=1 after 32 cycles, state IDLE, no res_valid; timeout_err stays 1 until reset.
- reset=0 asserted in EVAL -> all outputs at reset values asynchronously; after release, a new transaction completes correctly.
